// File: rtl/cla_mul_unit.sv
// Registered 32-bit arithmetic core: a two-level carry-lookahead adder and a
// low-half 32x32 multiplier, both fed by the same operands every cycle.
module cla_mul_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic [WIDTH-1:0] sum,
    output logic             overflow,
    output logic [WIDTH-1:0] product,
    output logic             out_valid
);
    localparam int GROUPS = WIDTH / 4;

    // Carry into position n written as a flat sum of products: a generate at j
    // propagated through every position above it, or cin propagated all the way.
    function automatic logic lookahead(input logic [7:0] gen, input logic [7:0] prop,
                                       input logic cin, input int n);
        logic carry;
        logic term;
        carry = 1'b0;
        for (int j = -1; j < n; j++) begin
            term = (j < 0) ? cin : gen[j[2:0]];
            for (int m = j + 1; m < n; m++) begin
                term = term & prop[m[2:0]];
            end
            carry = carry | term;
        end
        return carry;
    endfunction

    logic [WIDTH-1:0]  gBit;
    logic [WIDTH-1:0]  pBit;
    logic [WIDTH-1:0]  carryBit;
    logic [GROUPS-1:0] gGrp;
    logic [GROUPS-1:0] pGrp;
    logic [GROUPS:0]   carryGrp;
    logic [WIDTH-1:0]  mulLow;

    logic [WIDTH-1:0] sum_d, sum_q;
    logic             overflow_d, overflow_q;
    logic [WIDTH-1:0] product_d, product_q;
    logic             valid_d, valid_q;

    assign gBit = a & b;
    assign pBit = a ^ b;

    // Group G/P first, then every group carry straight from those, then bit carries inside each group.
    always_comb begin
        gGrp     = '0;
        pGrp     = '0;
        carryGrp = '0;
        carryBit = '0;
        for (int k = 0; k < GROUPS; k++) begin
            gGrp[k] = lookahead({4'b0, gBit[4*k +: 4]}, {4'b0, pBit[4*k +: 4]}, 1'b0, 4);
            pGrp[k] = &pBit[4*k +: 4];
        end
        for (int k = 0; k <= GROUPS; k++) begin
            carryGrp[k] = lookahead(gGrp, pGrp, c_in, k);
        end
        for (int k = 0; k < GROUPS; k++) begin
            for (int i = 0; i < 4; i++) begin
                carryBit[4*k + i] = lookahead({4'b0, gBit[4*k +: 4]}, {4'b0, pBit[4*k +: 4]},
                                              carryGrp[k], i);
            end
        end
    end

    always_comb begin
        mulLow = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (b[i]) begin
                mulLow = mulLow + (a << i);
            end
        end
    end

    assign sum_d      = pBit ^ carryBit;
    assign overflow_d = carryGrp[GROUPS];
    assign product_d  = mulLow;
    assign valid_d    = in_valid;

    // The datapath registers load every cycle; only the valid flag tracks in_valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q      <= '0;
            overflow_q <= 1'b0;
            product_q  <= '0;
            valid_q    <= 1'b0;
        end else begin
            sum_q      <= sum_d;
            overflow_q <= overflow_d;
            product_q  <= product_d;
            valid_q    <= valid_d;
        end
    end

    assign sum       = sum_q;
    assign overflow  = overflow_q;
    assign product   = product_q;
    assign out_valid = valid_q;
endmodule

// File: tb/tb_cla_mul_unit.sv
// Bench for cla_mul_unit: arithmetic reference model checked every cycle,
// plus literal expectations for the hand-computed corner cases.
module tb_cla_mul_unit;
    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [31:0] a;
    logic [31:0] b;
    logic        c_in;
    logic [31:0] sum;
    logic        overflow;
    logic [31:0] product;
    logic        out_valid;

    int checks = 0;
    int errors = 0;
    logic checkOn = 1'b0;

    logic [31:0] expSum;
    logic        expOv;
    logic [31:0] expProd;
    logic        expValid;

    cla_mul_unit #(.WIDTH(32)) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .a(a),
        .b(b),
        .c_in(c_in),
        .sum(sum),
        .overflow(overflow),
        .product(product),
        .out_valid(out_valid)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference: 33-bit sum for the carry-out, truncated product, one-cycle latency.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            expSum   <= 32'h0;
            expOv    <= 1'b0;
            expProd  <= 32'h0;
            expValid <= 1'b0;
        end else begin
            {expOv, expSum} <= {1'b0, a} + {1'b0, b} + {32'h0, c_in};
            expProd         <= 32'(a * b);
            expValid        <= in_valid;
        end
    end

    task automatic compareField(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
        end
    endtask

    always @(negedge clk) begin
        if (checkOn) begin
            compareField("model.sum", sum, expSum);
            compareField("model.overflow", {31'h0, overflow}, {31'h0, expOv});
            compareField("model.product", product, expProd);
            compareField("model.out_valid", {31'h0, out_valid}, {31'h0, expValid});
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] s, input logic ov,
                               input logic [31:0] p, input logic v);
        compareField({name, ".sum"}, sum, s);
        compareField({name, ".overflow"}, {31'h0, overflow}, {31'h0, ov});
        compareField({name, ".product"}, product, p);
        compareField({name, ".out_valid"}, {31'h0, out_valid}, {31'h0, v});
    endtask

    // Drive operands just after an edge, then wait until just after the next edge.
    task automatic applyStimulus(input logic [31:0] aIn, input logic [31:0] bIn,
                                 input logic cIn, input logic vIn);
        a        = aIn;
        b        = bIn;
        c_in     = cIn;
        in_valid = vIn;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        rst      = 1'b1;
        in_valid = 1'b0;
        a        = 32'h0;
        b        = 32'h0;
        c_in     = 1'b0;
        #1;
        checkOutput("reset", 32'h0, 1'b0, 32'h0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst     = 1'b0;
        checkOn = 1'b1;

        applyStimulus(32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b1);
        checkOutput("wrap", 32'h00000000, 1'b1, 32'hFFFFFFFF, 1'b1);
        applyStimulus(32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b1);
        checkOutput("signed_bound", 32'h80000000, 1'b0, 32'h7FFFFFFF, 1'b1);
        applyStimulus(32'h0000000F, 32'h00000000, 1'b1, 1'b1);
        checkOutput("carry_in", 32'h00000010, 1'b0, 32'h00000000, 1'b1);
        applyStimulus(32'h00000005, 32'hFFFFFFFD, 1'b0, 1'b1);
        checkOutput("sub_5_3", 32'h00000002, 1'b1, 32'hFFFFFFF1, 1'b1);
        applyStimulus(32'h00000003, 32'hFFFFFFFB, 1'b0, 1'b1);
        checkOutput("sub_3_5", 32'hFFFFFFFE, 1'b0, 32'hFFFFFFF1, 1'b1);
        applyStimulus(32'h00000005, 32'h00000000, 1'b0, 1'b1);
        checkOutput("sub_b_zero", 32'h00000005, 1'b0, 32'h00000000, 1'b1);
        applyStimulus(32'h00000007, 32'h00000006, 1'b0, 1'b1);
        checkOutput("mul_7_6", 32'h0000000D, 1'b0, 32'h0000002A, 1'b1);
        applyStimulus(32'hFFFFFFFD, 32'h00000005, 1'b0, 1'b1);
        checkOutput("mul_neg3_5", 32'h00000002, 1'b1, 32'hFFFFFFF1, 1'b1);
        applyStimulus(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b1);
        checkOutput("mul_ones", 32'hFFFFFFFE, 1'b1, 32'h00000001, 1'b1);
        applyStimulus(32'h00010000, 32'h00010000, 1'b0, 1'b1);
        checkOutput("mul_2p32", 32'h00020000, 1'b0, 32'h00000000, 1'b1);

        applyStimulus(32'h00000001, 32'h00000002, 1'b0, 1'b1);
        checkOutput("stream0", 32'h00000003, 1'b0, 32'h00000002, 1'b1);
        applyStimulus(32'd100, 32'd200, 1'b1, 1'b1);
        checkOutput("stream1", 32'h0000012D, 1'b0, 32'h00004E20, 1'b1);
        applyStimulus(32'h80000000, 32'h80000000, 1'b0, 1'b1);
        checkOutput("stream2", 32'h00000000, 1'b1, 32'h00000000, 1'b1);
        applyStimulus(32'h12345678, 32'h00000010, 1'b0, 1'b1);
        checkOutput("stream3", 32'h12345688, 1'b0, 32'h23456780, 1'b1);
        applyStimulus(32'h00000009, 32'h00000009, 1'b0, 1'b0);
        checkOutput("valid_drop", 32'h00000012, 1'b0, 32'h00000051, 1'b0);

        applyStimulus(32'h00000011, 32'h00000022, 1'b0, 1'b1);
        checkOutput("pre_reset", 32'h00000033, 1'b0, 32'h00000242, 1'b1);
        a        = 32'hDEADBEEF;
        b        = 32'h00001234;
        in_valid = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        checkOutput("async_reset", 32'h0, 1'b0, 32'h0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_held", 32'h0, 1'b0, 32'h0, 1'b0);
        rst = 1'b0;
        applyStimulus(32'h00000002, 32'h00000003, 1'b0, 1'b1);
        checkOutput("after_reset", 32'h00000005, 1'b0, 32'h00000006, 1'b1);

        for (int i = 0; i < 400; i++) begin
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 7))
                0: ra = 32'hFFFFFFFF;
                1: rb = 32'h0;
                2: rb = ~ra;
                3: rb = ~ra + 32'h1;
                default: ;
            endcase
            applyStimulus(ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0));
        end

        @(negedge clk);
        #1;
        checkOn = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/cla_mul_unit.md
Name: cla_mul_unit

Overview:
- Registered 32-bit arithmetic core for the ALU datapath.
- Contains a 32-bit carry-lookahead adder and a 32x32 multiplier whose low 32 bits are kept.
- Both results are computed every cycle from the same operands and captured into output registers on the clock edge.
- The ALU uses the adder for add, subtract (with a pre-negated B) and unsigned compare via the carry, and uses the multiplier for mul.

Parameters:
- WIDTH, 32, operand and result width. Only 32 must be supported; the CLA grouping below assumes 32.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operands valid this cycle.
- a  in  32  operand A.
- b  in  32  operand B.
- c_in  in  1  adder carry-in.
- sum  out  32  registered a + b + c_in, modulo 2^32.
- overflow  out  1  registered carry-out of bit 31 of the adder.
- product  out  32  registered low 32 bits of a * b.
- out_valid  out  1  registered in_valid.

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-high (ports clk, rst).
  - While rst=1: sum, overflow, product and out_valid are all 0 immediately, independent of clk.
  - Deassertion takes effect at the next rising edge.
- Adder:
  - Structure is eight 4-bit CLA groups. Each group uses bit generate g=a&b and propagate p=a^b, and produces group G/P.
  - A second-level lookahead over the group G/P signals generates the group carries (c4, c8, ..., c32). No ripple between groups.
  - sum[i] = p[i] ^ c[i], with c[0] = c_in.
  - overflow = c32, i.e. the unsigned carry-out. It is not the signed two's-complement overflow.
  - When b is pre-negated (~B+1), overflow=1 means a >= b unsigned, with one exception: for b=0, ~0+1=0, so overflow=0.
- Multiplier:
  - Unsigned 32x32 shift-add (array or Wallace) implementation. Only the low 32 bits of the product are kept.
  - The low 32 bits are identical for signed and unsigned operands, so there is no signedness input.
  - It must be combinational within one clock period; no internal pipeline stages.
- Timing:
  - Latency is exactly 1 cycle: operands and c_in sampled at rising edge N appear on sum/overflow/product at edge N.
  - out_valid at edge N equals in_valid sampled at edge N.
  - Throughput is 1 operation per cycle. Back-to-back operands are allowed with no stall and no handshake backpressure.
- in_valid=0:
  - Output registers still load the computed values (datapath is free-running).
  - out_valid drops to 0; consumers qualify the results with out_valid.
- Reset mid-stream: any in-flight result is discarded. The first valid output after reset comes from the first in_valid=1 sample after deassertion.
- X/undefined operands are not required to be handled; no internal state exists beyond the output registers.

Test Plan:
- Carry-out wrap: a=0xFFFFFFFF, b=0x00000001, c_in=0 -> next edge sum=0x00000000, overflow=1, product=0xFFFFFFFF, out_valid=1.
- Signed-overflow boundary and carry-in:
  - a=0x7FFFFFFF, b=1, c_in=0 -> sum=0x80000000, overflow=0.
  - a=0x0000000F, b=0, c_in=1 -> sum=0x00000010, overflow=0.
- Subtract via negated B:
  - a=5, b=0xFFFFFFFD (i.e. -3) -> sum=2, overflow=1.
  - a=3, b=0xFFFFFFFB (i.e. -5) -> sum=0xFFFFFFFE, overflow=0.
- Multiply:
  - 7*6 -> product=42.
  - 0xFFFFFFFD*5 -> product=0xFFFFFFF1.
  - 0xFFFFFFFF*0xFFFFFFFF -> product=0x00000001.
  - 0x00010000*0x00010000 -> product=0x00000000.
- Streaming: apply four different operand sets on consecutive cycles with in_valid=1 -> four consecutive correct results, each one cycle after its operands. Then drop in_valid -> out_valid=0 on the next edge.
- Async reset: during the streaming test, assert rst between clock edges -> all outputs go to 0 before the next edge. Hold rst for 2 cycles, release, apply a=2, b=3 -> sum=5, product=6, out_valid=1 one cycle later.
